// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: opcode, ALU op, state and field constants shared by the sequencer
package reg_alu_pkg;
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_ALU  = 3'b010;
    localparam logic [2:0] OP_MOV  = 3'b011;
    localparam logic [2:0] OP_RADD = 3'b100;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;
    localparam int OPC_LSB = 13;
    localparam int RD_LSB  = 10;
    localparam int RA_LSB  = 7;
    localparam int RB_LSB  = 4;
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
endpackage

// File: rtl/reg_alu_dec.sv
// reg_alu_dec: combinational decode of the latched instruction into datapath controls
module reg_alu_dec
    import reg_alu_pkg::*;
(
    input  logic [15:0] inst,
    output logic        sel,
    output logic [1:0]  op,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic        legal,
    output logic        writes,
    output logic        is_repeat,
    output logic        n_zero
);
    logic [2:0] opc, rd, ra, rb;
    always_comb begin
        opc       = inst[OPC_LSB +: 3];
        rd        = inst[RD_LSB +: 3];
        ra        = inst[RA_LSB +: 3];
        rb        = inst[RB_LSB +: 3];
        legal     = opc <= OP_RADD;
        is_repeat = opc == OP_RADD;
        writes    = legal && opc != OP_NOP;
        n_zero    = inst[3:0] == 4'd0;
        sel       = opc == OP_ALU || opc == OP_MOV || is_repeat;
        // MOV is an AND of ra with itself; RADD accumulates into rd
        op        = opc == OP_ALU ? inst[1:0] : opc == OP_MOV ? ALU_AND : ALU_ADD;
        rd_addr_a = is_repeat ? rd : ra;
        rd_addr_b = is_repeat || opc == OP_MOV ? ra : rb;
        wr_addr   = rd;
    end
endmodule

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: multi-cycle IDLE/EXEC/WB sequencer driving the reg_alu control inputs
module reg_alu_seq
    import reg_alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_valid,
    input  logic [15:0] inst,
    input  logic [15:0] imm,
    output logic        inst_ready,
    output logic        sel,
    output logic        wr,
    output logic [1:0]  op,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic [15:0] d_in,
    output logic        done,
    output logic        err
);
    state_t      state_q, state_d;
    logic [15:0] inst_q, inst_d, imm_q, imm_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d, err_q, err_d;
    logic        dsel, legal, writes, is_repeat, n_zero, act;
    logic [1:0]  dop;
    logic [2:0]  da, db, dw;

    reg_alu_dec u_dec (
        .inst(inst_q), .sel(dsel), .op(dop), .rd_addr_a(da), .rd_addr_b(db), .wr_addr(dw),
        .legal(legal), .writes(writes), .is_repeat(is_repeat), .n_zero(n_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            inst_q  <= '0;
            imm_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            imm_q   <= imm_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        imm_d   = imm_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (inst_valid) begin
                state_d = EXEC;
                inst_d  = inst;
                imm_d   = imm;
                cnt_d   = inst[3:0];
            end
            EXEC: if (!writes || (is_repeat && n_zero)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = !legal;
            end else state_d = WB;
            WB: if (is_repeat && cnt_q > 4'd1) begin
                state_d = EXEC;
                cnt_d   = cnt_q - 4'd1;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs decode straight from state so reset clears wr without waiting for an edge
    always_comb begin
        act        = state_q != IDLE;
        inst_ready = state_q == IDLE;
        wr         = state_q == WB;
        sel        = act && dsel;
        op         = act ? dop : ALU_ADD;
        rd_addr_a  = act ? da : 3'd0;
        rd_addr_b  = act ? db : 3'd0;
        wr_addr    = act ? dw : 3'd0;
        d_in       = act ? imm_q : 16'd0;
        done       = done_q;
        err        = err_q;
    end
endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq: directed checks of reg_alu_seq against a behavioural register file and ALU
module tb_reg_alu_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_valid = 1'b0;
    logic [15:0] inst = '0, imm = '0;
    logic        inst_ready, sel, wr, done, err;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [15:0] d_in;
    logic [15:0] rf [8];
    logic [15:0] a, b, alu;
    int checks = 0, errors = 0;

    reg_alu_seq dut (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst(inst), .imm(imm),
        .inst_ready(inst_ready), .sel(sel), .wr(wr), .op(op), .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .d_in(d_in), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // stand-in for the reg_alu datapath so register effects can be observed
    always_comb begin
        a   = rf[rd_addr_a];
        b   = rf[rd_addr_b];
        alu = op == 2'b00 ? a + b : op == 2'b01 ? a - b : op == 2'b10 ? a & b : a | b;
    end
    always @(posedge clk) if (wr) rf[wr_addr] <= sel ? alu : d_in;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] opc, rd, ra, rb, input logic [3:0] n);
        return {opc, rd, ra, rb, n};
    endfunction

    task automatic wait_ready();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!inst_ready && t < 20);
        if (!inst_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic exec(input string tag, input logic [15:0] i, input logic [15:0] m,
                        input int ewr, input int edone, input logic eerr);
        int nwr = 0, dc = 0;
        logic er = 1'b0, rbad = 1'b0;
        wait_ready();
        inst = i; imm = m; inst_valid = 1'b1;
        @(posedge clk); #1 inst_valid = 1'b0;
        for (int c = 1; c <= 40 && dc == 0; c++) begin
            @(negedge clk);
            nwr += int'(wr);
            if (done) begin
                dc = c;
                er = err;
            end else if (inst_ready) rbad = 1'b1;
        end
        check({tag, "_wr"}, nwr, ewr);
        check({tag, "_done"}, dc, edone);
        check({tag, "_err"}, er, eerr);
        check({tag, "_rdy"}, rbad, 0);
    endtask

    initial begin
        int acc [3];
        int nwr, dn;
        for (int i = 0; i < 8; i++) rf[i] = '0;
        #12;
        check("rst_ready", inst_ready, 1);
        check("rst_ctl", {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, done, err}, 0);
        check("rst_din", d_in, 0);
        @(negedge clk); reset = 1'b0;

        inst = mk(3'b001, 3'd3, 3'd0, 3'd0, 4'd0); imm = 16'h1234; inst_valid = 1'b1;
        @(posedge clk); #1 inst_valid = 1'b0;
        @(negedge clk);
        check("ldi_exec", {inst_ready, wr, done}, 3'b000);
        @(negedge clk);
        check("ldi_wb", {wr, sel, wr_addr}, {1'b1, 1'b0, 3'd3});
        check("ldi_din", d_in, 16'h1234);
        @(negedge clk);
        check("ldi_done", {done, inst_ready, wr, err}, 4'b1100);
        check("r3", rf[3], 16'h1234);

        exec("ldi1", mk(3'b001, 3'd1, 3'd0, 3'd0, 4'd0), 16'd5, 1, 3, 1'b0);
        exec("ldi2", mk(3'b001, 3'd2, 3'd0, 3'd0, 4'd0), 16'd7, 1, 3, 1'b0);
        exec("sub", mk(3'b010, 3'd4, 3'd1, 3'd2, 4'd1), 16'd0, 1, 3, 1'b0);
        check("r4", rf[4], 16'hFFFE);
        exec("or", mk(3'b010, 3'd5, 3'd1, 3'd2, 4'd3), 16'd0, 1, 3, 1'b0);
        check("r5", rf[5], 16'h0007);
        exec("mov", mk(3'b011, 3'd0, 3'd3, 3'd5, 4'd0), 16'd0, 1, 3, 1'b0);
        check("r0", rf[0], 16'h1234);
        exec("radd4", mk(3'b100, 3'd6, 3'd1, 3'd0, 4'd4), 16'd0, 4, 9, 1'b0);
        check("r6", rf[6], 16'd20);
        exec("ill", mk(3'b110, 3'd6, 3'd1, 3'd0, 4'd4), 16'hFFFF, 0, 2, 1'b1);
        exec("nop", mk(3'b000, 3'd6, 3'd1, 3'd0, 4'd0), 16'hFFFF, 0, 2, 1'b0);
        exec("radd0", mk(3'b100, 3'd6, 3'd1, 3'd0, 4'd0), 16'd0, 0, 2, 1'b0);
        check("r6_keep", rf[6], 16'd20);
        exec("dbl", mk(3'b100, 3'd2, 3'd2, 3'd0, 4'd2), 16'd0, 2, 5, 1'b0);
        check("r2_dbl", rf[2], 16'd28);

        wait_ready();
        inst_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            int t = 0;
            inst = mk(3'b001, 3'(j + 4), 3'd0, 3'd0, 4'd0);
            imm = 16'(16'hA000 + j);
            while (!inst_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
            acc[j] = int'($time / 10);
            #1;
        end
        inst_valid = 1'b0;
        wait_ready();
        check("b2b_gap1", acc[1] - acc[0], 3);
        check("b2b_gap2", acc[2] - acc[1], 3);
        check("b2b_regs", {rf[4], rf[5], rf[6]}, {16'hA000, 16'hA001, 16'hA002});

        inst = mk(3'b100, 3'd7, 3'd3, 3'd0, 4'd8); imm = 16'd0; inst_valid = 1'b1;
        @(posedge clk); #1 inst_valid = 1'b0;
        nwr = 0;
        for (int c = 0; c < 40 && nwr < 3; c++) begin
            @(negedge clk);
            nwr += int'(wr);
        end
        check("rst_wb_seen", nwr, 3);
        reset = 1'b1;
        #1;
        check("rst_async", {wr, inst_ready}, 2'b01);
        @(negedge clk); reset = 1'b0;
        check("r7_partial", rf[7], 16'h2468);
        dn = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            dn += int'(done) + int'(wr);
        end
        check("rst_quiet", dn, 0);
        check("r7_hold", rf[7], 16'h2468);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
